// File: rtl/pixel_stream_pkg.sv
// Shared constants and state encoding for the pixel frame streamer.
package pixel_stream_pkg;

    localparam int DEPTH    = 2048;
    localparam int N_PIXELS = 784;
    localparam int ADDR_W   = 11;
    localparam int IDX_W    = 10;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO; entry 0 is the head and drives dout directly.
module skid_fifo2 #(
    parameter int DATA_W = pixel_stream_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     pop,
    output logic signed [DATA_W-1:0] dout,
    output logic [1:0]               count
);

    logic signed [DATA_W-1:0] head_q;
    logic signed [DATA_W-1:0] tail_q;
    logic [1:0]               count_q;

    // Head is cleared on reset so the visible sample reads zero; the tail is never observed empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) head_q <= din;
                    else                 head_q <= tail_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((push && !pop && count_q == 2'd1) || (push && pop && count_q == 2'd2))
            tail_q <= din;
    end

    assign dout  = head_q;
    assign count = count_q;

endmodule

// File: rtl/pixel_stream_ctrl.sv
// Streams one frame of signed bytes from a synchronous byte memory as sign-extended
// samples over valid/ready, with at most two samples buffered or in flight.
module pixel_stream_ctrl
    import pixel_stream_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [7:0]        mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last
);

    function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] b);
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

    state_t                   state_q;
    state_t                   state_d;
    logic [ADDR_W-1:0]        base_q;
    logic [IDX_W-1:0]         issued_q;
    logic [IDX_W-1:0]         beat_q;
    logic                     vld_p1;
    logic [1:0]               fifo_count;
    logic signed [DATA_W-1:0] fifo_dout;
    logic                     pop;
    logic                     last_hs;
    logic                     start_acc;
    logic [2:0]               credit;

    assign start_acc = (state_q == IDLE) && start;
    assign pop       = out_valid && out_ready;
    assign last_hs   = pop && (beat_q == IDX_W'(N_PIXELS - 1));
    // A pop this cycle frees a slot for the read issued in the same cycle.
    assign credit    = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_hs) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_en   = 1'b0;
        mem_addr = '0;
        unique case (state_q)
            RUN: begin
                busy = 1'b1;
                if (issued_q != IDX_W'(N_PIXELS) && credit < 3'd2) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + ADDR_W'(issued_q);
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start_acc) base_q <= base_addr;
    end

    // Stage p0 -> p1: read issued this cycle, byte returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            beat_q   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= mem_en;
            if (start_acc) begin
                issued_q <= '0;
                beat_q   <= '0;
            end else begin
                if (mem_en) issued_q <= issued_q + IDX_W'(1);
                if (pop)    beat_q   <= last_hs ? '0 : beat_q + IDX_W'(1);
            end
        end
    end

    // Stage p1 -> FIFO: the returned byte is widened and buffered before it is visible.
    skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_p1),
        .din   (sext8(mem_rdata)),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_dout;
    assign out_index = beat_q;
    assign out_last  = out_valid && (beat_q == IDX_W'(N_PIXELS - 1));

endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Bench for pixel_stream_ctrl: frame table plus scoreboard of expected beats and read addresses.
module tb_pixel_stream_ctrl;

    localparam int NPIX = 784;
    localparam int DEP  = 2048;

    typedef struct {
        int base;
        int pat;
        int pct;
        int exp_done;
        int poke;
        int rst_beat;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [9:0]  idx;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0]  b;
        logic [31:0] exp;
    } sx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic        busy, done, mem_en, out_valid, out_last;
    logic        out_ready = 1'b0;
    logic [10:0] mem_addr;
    logic signed [7:0] mem_rdata;
    logic [31:0] out_data;
    logic [9:0]  out_index;

    logic [7:0]  mem [0:DEP-1];
    beat_t       exp_q[$];
    logic [10:0] addr_q[$];
    logic [31:0] cap_d [0:3];

    int n_cmp = 0, n_bad = 0;
    int pct = 0, hs_cnt = 0, mem_cnt = 0, done_cnt = 0, outstd = 0;
    logic rst_edge = 1'b1, prev_hold = 1'b0;
    logic [31:0] prev_d = '0;
    logic [9:0]  prev_i = '0;

    vec_t vecs[6];
    sx_t  sx[4];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    pixel_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        beat_t e;
        logic  hs;
        if (rst_edge) outstd = 0;
        if (mem_en) begin
            mem_cnt++;
            chk("read_expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
        hs = out_valid && out_ready;
        if (hs) begin
            hs_cnt++;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_index", 32'(out_index), 32'(e.idx));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
            if (out_index < 10'd4) cap_d[out_index[1:0]] = out_data;
        end
        if (prev_hold && !rst_edge) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, prev_d);
            chk("hold_index", 32'(out_index), 32'(prev_i));
        end
        if (mem_en || hs) begin
            outstd += int'(mem_en) - int'(hs);
            chk("reads_ahead_le2", 32'(outstd <= 2), 32'd1);
        end
        if (done) done_cnt++;
        prev_hold = out_valid && !out_ready;
        prev_d    = out_data;
        prev_i    = out_index;
    endtask

    task automatic cyc_step();
        @(posedge clk);
        rst_edge = rst;
        #1;
        out_ready = (int'($urandom_range(99)) < pct);
        @(negedge clk);
        monitor();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_index"}, 32'(out_index), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
    endtask

    task automatic load_mem(input int pat);
        for (int i = 0; i < DEP; i++)
            mem[i] = (pat == 2) ? 8'($urandom) : 8'(i % 256);
        if (pat == 1)
            for (int j = 0; j < 4; j++) mem[j] = sx[j].b;
    endtask

    task automatic run_frame(input vec_t v);
        int h0, m0, d0, rel;
        bit got_done, poked;
        load_mem(v.pat);
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            int a;
            beat_t e;
            a = (v.base + i) % DEP;
            e.d    = {{24{mem[a][7]}}, mem[a]};
            e.idx  = 10'(i);
            e.last = (i == NPIX - 1);
            exp_q.push_back(e);
            addr_q.push_back(11'(a));
        end
        pct = v.pct;
        h0 = hs_cnt; m0 = mem_cnt; d0 = done_cnt;
        got_done = 0; poked = 0;
        base_addr = 11'(v.base);
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        rel = 1;
        chk("c1_busy", 32'(busy), 1);
        chk("c1_mem_en", 32'(mem_en), 1);
        chk("c1_mem_addr", 32'(mem_addr), 32'(v.base));
        while (rel < 6000) begin
            if (v.pct == 100 && rel == 2) chk("c2_out_valid", 32'(out_valid), 0);
            if (v.pct == 100 && rel == 3) begin
                chk("c3_out_valid", 32'(out_valid), 1);
                chk("c3_out_index", 32'(out_index), 0);
            end
            if (done) begin
                got_done = 1;
                if (v.exp_done > 0) chk("done_cycle", 32'(rel), 32'(v.exp_done));
                chk("busy_at_done", 32'(busy), 0);
                break;
            end
            if (v.rst_beat >= 0 && hs_cnt - h0 == v.rst_beat + 1) begin
                rst = 1'b1;
                cyc_step();
                rst = 1'b0;
                chk_zero("midrst");
                exp_q.delete();
                addr_q.delete();
                return;
            end
            start = 1'b0;
            base_addr = 11'(v.base);
            if (v.poke >= 0 && hs_cnt - h0 == v.poke && !poked) begin
                start = 1'b1;
                base_addr = 11'(v.base + 333);
                poked = 1;
            end
            cyc_step();
            rel++;
        end
        start = 1'b0;
        chk("done_seen", 32'(got_done), 1);
        cyc_step();
        chk("after_done_done", 32'(done), 0);
        chk("after_done_busy", 32'(busy), 0);
        chk("beats_left", 32'(exp_q.size()), 0);
        chk("reads_left", 32'(addr_q.size()), 0);
        chk("read_count", 32'(mem_cnt - m0), 32'(NPIX));
        chk("beat_count", 32'(hs_cnt - h0), 32'(NPIX));
        chk("done_pulses", 32'(done_cnt - d0), 1);
    endtask

    initial begin
        vec_t v5;
        sx[0] = '{8'h80, 32'hFFFF_FF80};
        sx[1] = '{8'hFF, 32'hFFFF_FFFF};
        sx[2] = '{8'h00, 32'h0000_0000};
        sx[3] = '{8'h7F, 32'h0000_007F};
        //          base  pat pct  done  poke rst
        vecs[0] = '{0,    0,  100, 787,  -1,  -1};
        vecs[1] = '{0,    1,  100, 787,  -1,  -1};
        vecs[2] = '{1800, 0,  100, 787,  -1,  -1};
        vecs[3] = '{37,   2,  30,  -1,   -1,  -1};
        vecs[4] = '{2000, 0,  100, 787,  50,  -1};
        vecs[5] = '{0,    0,  100, -1,   -1,  100};

        rst = 1'b1;
        repeat (3) cyc_step();
        chk_zero("reset");
        rst = 1'b0;
        cyc_step();

        for (int k = 0; k < 6; k++) begin
            run_frame(vecs[k]);
            if (k == 1)
                for (int j = 0; j < 4; j++) chk("sext_table", cap_d[j], sx[j].exp);
        end

        // After the mid-frame reset, a fresh frame must start cleanly from beat 0.
        cyc_step();
        chk_zero("idle_after_rst");
        v5 = '{5, 2, 100, 787, -1, -1};
        run_frame(v5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
